audio_sfx_mixer: RTL

Mixes one-shot game sound effects (jump, gem, door, death) over the background music stream before PWM conversion. It sits between the BRAM music player and the PWM audio generator. Each 16 kHz sample tick, it takes the player's 8-bit music sample, fetches the current effect sample from a dedicated SFX ROM, sums both with saturation, and hands the 8-bit result to the PWM stage.

---
 rtl/audio_sfx_mixer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/audio_sfx_mixer.sv
`default_nettype none
// audio_sfx_mixer: saturating mix of one-shot SFX ROM samples over the music stream, one sample per tick.
// Revision 1.0
module audio_sfx_mixer #(
   parameter int SLOT_W = 12,
   parameter int N_SFX  = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              sample_tick,
   input  logic [7:0]        music_in,
   input  logic [N_SFX-1:0]  sfx_trig,
   input  logic [1:0]        music_vol,
   output logic [1+SLOT_W:0] sfx_rom_addr,
   input  logic [7:0]        sfx_rom_data,
   output logic [7:0]        mix_out,
   output logic              mix_valid,
   output logic              sfx_busy,
   output logic [1:0]        sfx_id
);
   localparam int ID_W = 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_MIX   = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic              fetch_en;
   logic              capture_en;
   logic              mix_en;

   logic              trig_any;
   logic [ID_W-1:0]   trig_id;
   logic              pend_valid;
   logic [ID_W-1:0]   pend_id;
   logic              cand_valid;
   logic [ID_W-1:0]   cand_id;
   logic              accept;

   logic [SLOT_W-1:0] offset;
   logic [7:0]        music_lat;
   logic [7:0]        rom_lat;

   logic signed [9:0] music_c;
   logic signed [9:0] music_att;
   logic signed [9:0] sfx_c;
   logic signed [9:0] sum;
   logic [7:0]        mix_next;

   // FSM: state register
   always_ff @(posedge CLK) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (sample_tick) state_next = S_FETCH;
         S_FETCH: state_next = S_WAIT;
         S_WAIT:  state_next = S_MIX;
         S_MIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // FSM: stage enables
   always_comb begin
      fetch_en   = (state == S_IDLE) && sample_tick;
      capture_en = (state == S_WAIT);
      mix_en     = (state == S_MIX);
   end

   // Lowest set trigger bit wins
   always_comb begin
      trig_any = 1'b0;
      trig_id  = '0;
      for (int i = N_SFX - 1; i >= 0; i--) begin
         if (sfx_trig[i]) begin
            trig_any = 1'b1;
            trig_id  = ID_W'(i);
         end
      end
   end

   // A trigger arriving with the tick takes precedence over an older pending one.
   always_comb begin
      cand_valid = trig_any | pend_valid;
      cand_id    = trig_any ? trig_id : pend_id;
      accept     = fetch_en && cand_valid && (!sfx_busy || (cand_id <= sfx_id));
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend_valid <= 1'b0;
         pend_id    <= '0;
      end else if (fetch_en) begin
         pend_valid <= 1'b0;
      end else if (trig_any) begin
         pend_valid <= 1'b1;
         pend_id    <= trig_id;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sfx_busy     <= 1'b0;
         sfx_id       <= '0;
         offset       <= '0;
         sfx_rom_addr <= '0;
         music_lat    <= 8'd128;
         rom_lat      <= 8'd128;
         mix_out      <= 8'd128;
         mix_valid    <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         if (fetch_en) begin
            music_lat <= music_in;
            if (accept) begin
               sfx_busy     <= 1'b1;
               sfx_id       <= cand_id;
               offset       <= '0;
               sfx_rom_addr <= {cand_id, {SLOT_W{1'b0}}};
            end else if (sfx_busy) begin
               sfx_rom_addr <= {sfx_id, offset};
            end
         end
         if (capture_en) rom_lat <= sfx_rom_data;
         if (mix_en) begin
            mix_out   <= mix_next;
            mix_valid <= 1'b1;
            if (sfx_busy) begin
               // Last sample of the slot ends the effect; it never wraps or replays.
               if (&offset) sfx_busy <= 1'b0;
               else         offset   <= offset + SLOT_W'(1);
            end
         end
      end
   end

   always_comb begin
      music_c   = $signed({2'b00, music_lat}) - 10'sd128;
      music_att = music_c >>> music_vol;
      sfx_c     = sfx_busy ? ($signed({2'b00, rom_lat}) - 10'sd128) : 10'sd0;
      sum       = music_att + sfx_c;
      if (sum > 10'sd127)       mix_next = 8'd255;
      else if (sum < -10'sd128) mix_next = 8'd0;
      else                      mix_next = sum[7:0] ^ 8'h80;
   end

endmodule
`default_nettype wire
